// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder evaluated once per clock, LSB first, with a
// start/busy/done handshake around the WIDTH-cycle add.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] s_reg, s_next;
    logic             c_reg, c_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] s_shifted;

    // One-bit full adder on the current LSBs and the registered carry.
    assign fa_s  = a_reg[0] ^ b_reg[0] ^ c_reg;
    assign fa_co = (a_reg[0] & b_reg[0]) | (c_reg & (a_reg[0] ^ b_reg[0]));

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
    generate
        if (WIDTH == 1) begin : g_shift_narrow
            assign s_shifted = fa_s;
        end else begin : g_shift_wide
            assign s_shifted = {fa_s, s_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            c_reg     <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            s_reg     <= s_next;
            c_reg     <= c_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        s_next     = s_reg;
        c_next     = c_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a_in;
                    b_next     = b_in;
                    c_next     = cin_in;
                    s_next     = '0;
                    cnt_next   = '0;
                    state_next = ADD;
                end
            end
            ADD: begin
                a_next   = a_reg >> 1;
                b_next   = b_reg >> 1;
                c_next   = fa_co;
                s_next   = s_shifted;
                cnt_next = cnt_reg + 1'b1;
                // Result registers only update here, so partial sums stay hidden.
                if (cnt_reg == LAST_BIT) begin
                    sum_next   = s_shifted;
                    cout_next  = fa_co;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == ADD);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised and directed bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1)
// with per-instance result queues checked by independent monitors.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int compared = 0;
    int mismatched = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] hold8 = '0;
    logic [1:0] hold1 = '0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
        .cin_in(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
        .cin_in(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop an expected result on each done, else require the result to hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done8) begin
                check("w8 done_with_busy", {31'd0, busy8}, 32'd0);
                if (q8.size() == 0) begin
                    check("w8 unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [8:0] e;
                    e = q8.pop_front();
                    check("w8 result", {23'd0, cout8, sum8}, {23'd0, e});
                    $display("w8 done: sum=0x%02h cout=%0d expected sum=0x%02h cout=%0d",
                             sum8, cout8, e[7:0], e[8]);
                end
            end else begin
                check("w8 result_hold", {23'd0, cout8, sum8}, {23'd0, hold8});
            end
        end
        hold8 = {cout8, sum8};
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (done1) begin
                check("w1 done_with_busy", {31'd0, busy1}, 32'd0);
                if (q1.size() == 0) begin
                    check("w1 unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [1:0] e;
                    e = q1.pop_front();
                    check("w1 result", {30'd0, cout1, sum1}, {30'd0, e});
                    $display("w1 done: {cout,sum}=%b expected %b", {cout1, sum1}, e);
                end
            end else begin
                check("w1 result_hold", {30'd0, cout1, sum1}, {30'd0, hold1});
            end
        end
        hold1 = {cout1, sum1};
    end

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while ((busy8 || done8) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("w8 idle_timeout", 32'd1, 32'd0);
    endtask

    // One WIDTH=8 add; inject>0 pulses a bogus start with 0xFF operands at that cycle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input int inject);
        int n = 0;
        int busy_cnt = 0;
        wait_idle8();
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        q8.push_back(9'(a) + 9'(b) + 9'(cin));
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (busy8) busy_cnt++;
            if (done8) break;
            if (n == inject) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            end else begin
                start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
        end
        start8 = 1'b0;
        check("w8 done_latency", 32'(n), 32'd9);
        check("w8 busy_cycles", 32'(busy_cnt), 32'd8);
    endtask

    task automatic run1(input logic a, input logic b, input logic cin, input logic [1:0] exp);
        int n = 0;
        int busy_cnt = 0;
        @(negedge clk);
        while ((busy1 || done1) && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        a1 = a; b1 = b; cin1 = cin; start1 = 1'b1;
        q1.push_back(exp);
        while (n < 10) begin
            @(negedge clk);
            n++;
            start1 = 1'b0;
            if (busy1) busy_cnt++;
            if (done1) break;
        end
        check("w1 done_latency", 32'(n), 32'd2);
        check("w1 busy_cycles", 32'(busy_cnt), 32'd1);
    endtask

    initial begin
        logic [15:0] w1_table;
        logic [2:0]  combo;

        #1;
        check("reset busy", {31'd0, busy8}, 32'd0);
        check("reset done", {31'd0, done8}, 32'd0);
        check("reset sum", {24'd0, sum8}, 32'd0);
        check("reset cout", {31'd0, cout8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run8(8'h00, 8'h00, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 0);
        run8(8'hA5, 8'h5A, 1'b1, 0);
        run8(8'h3C, 8'h41, 1'b0, 0);
        run8(8'h10, 8'h20, 1'b0, 3);

        // Abort an add mid-flight: outputs clear at once and no done follows.
        wait_idle8();
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort busy_before", {31'd0, busy8}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy8}, 32'd0);
        check("abort done", {31'd0, done8}, 32'd0);
        check("abort sum", {24'd0, sum8}, 32'd0);
        check("abort cout", {31'd0, cout8}, 32'd0);
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run8(8'h77, 8'h11, 1'b1, 0);

        for (int i = 0; i < 20; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), 0);
        end

        // WIDTH=1 truth table, listed as {cout,sum} for {a,b,cin} = 000..111.
        w1_table = {2'b11, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            run1(combo[2], combo[1], combo[0], w1_table[2*i +: 2]);
        end
        for (int i = 0; i < 8; i++) begin
            logic ra, rb, rc;
            ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom);
            run1(ra, rb, rc, 2'(ra) + 2'(rb) + 2'(rc));
        end

        repeat (4) @(negedge clk);
        check("w8 queue_drained", 32'(q8.size()), 32'd0);
        check("w1 queue_drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
